pulse_stretch: RTL and testbench

PULSE_STRETCH -- requirements
Module: pulse_stretch

---
 rtl/pulse_pkg.sv | 14 +
 rtl/tick_gen.sv | 39 +++
 rtl/pulse_stretch.sv | 134 +++++++++++++
 tb/tb_pulse_stretch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher.
//   state_t : FSM encoding (IDLE / ON / GAP)
//   PEND_W  : width of the queued-event counter
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned PEND_W = 4;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every PRESCALE enabled clock cycles.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   en   : count enable
//   clr  : synchronous clear of the count (takes priority over en)
//   tick : high while the count is at its terminal value and en is high
module tick_gen #(
  parameter int unsigned PRESCALE = 32'h000fffff
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [31:0] TERM = 32'(PRESCALE - 1);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == TERM);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle trigger events into human-visible LED pulses.
// Each event shows led high for HOLD_TICKS ticks, followed by a forced-low
// gap of GAP_TICKS ticks. Events arriving while busy are queued (up to
// MAX_PEND); further events are dropped and flagged.
//   clk     : clock
//   rst     : asynchronous active-high reset
//   trig    : event request, one event per high cycle
//   led     : registered stretched pulse
//   busy    : an event is being shown or is queued
//   dropped : one-cycle pulse when an event is lost to a full queue
module pulse_stretch
  import pulse_pkg::*;
#(
  parameter int unsigned PRESCALE   = 32'h000fffff,
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned GAP_TICKS  = 4,
  parameter int unsigned MAX_PEND   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic led,
  output logic busy,
  output logic dropped
);

  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [7:0]        HOLD_LOAD = 8'(HOLD_TICKS);
  localparam logic [7:0]        GAP_LOAD  = 8'(GAP_TICKS);

  state_t            state_q, state_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              led_q, led_d;
  logic              tick, last_tick, dec, accept, drop, transition;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (state_q != IDLE),
    .clr (transition),
    .tick(tick)
  );

  // Next state; dec marks the edge where a queued event is pulled into ON.
  always_comb begin
    state_d   = state_q;
    dec       = 1'b0;
    last_tick = tick && (tcnt_q == 8'd1);
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = ON;
        end else if (pend_q != '0) begin
          state_d = ON;
          dec     = 1'b1;
        end
      end
      ON: begin
        if (last_tick) state_d = GAP;
      end
      GAP: begin
        if (last_tick) begin
          if (pend_q != '0) begin
            state_d = ON;
            dec     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign transition = (state_d != state_q);

  // Queue: a trig while showing is queued; when it coincides with a dequeue
  // the two cancel and pend holds. A trig in IDLE starts ON directly.
  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;
    accept = trig && (state_q != IDLE);
    if (accept && dec) begin
      pend_d = pend_q;
    end else if (accept) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end else if (dec) begin
      pend_d = pend_q - PEND_ONE;
    end
  end

  always_comb begin
    tcnt_d = tcnt_q;
    if (transition) begin
      unique case (state_d)
        ON:      tcnt_d = HOLD_LOAD;
        GAP:     tcnt_d = GAP_LOAD;
        default: tcnt_d = 8'd0;
      endcase
    end else if (tick && (tcnt_q != 8'd0)) begin
      tcnt_d = tcnt_q - 8'd1;
    end
  end

  // led mirrors the registered state through its own flop.
  assign led_d = (state_d == ON);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= 8'd0;
      pend_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
    end
  end

  assign led     = led_q;
  assign busy    = (state_q != IDLE) || (pend_q != '0);
  assign dropped = drop;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch with PRESCALE=4, HOLD_TICKS=3,
// GAP_TICKS=2, MAX_PEND=3. Each scenario logs led/busy/dropped/pend per
// cycle and compares against hand-computed spans of expected values.
module tb_pulse_stretch;
  import pulse_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic trig = 1'b0;
  logic led, busy, dropped;

  pulse_stretch #(
    .PRESCALE  (4),
    .HOLD_TICKS(3),
    .GAP_TICKS (2),
    .MAX_PEND  (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .trig   (trig),
    .led    (led),
    .busy   (busy),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int   scen;
    int   lo;
    int   hi;
    logic led;
    logic busy;
    logic drop;
    int   pend;
  } span_t;

  span_t spans[$];

  logic lg_led[200];
  logic lg_busy[200];
  logic lg_drop[200];
  int   lg_pend[200];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic span_t mk(input int s, input int lo, input int hi, input logic l,
                               input logic b, input logic d, input int p);
    span_t r;
    r.scen = s; r.lo = lo; r.hi = hi; r.led = l; r.busy = b; r.drop = d; r.pend = p;
    return r;
  endfunction

  // Reset, then drive trig = pat[c] during cycle c and sample at the negedge.
  task automatic run(input logic [199:0] pat, input int n);
    trig = 1'b0;
    rst  = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1 trig = pat[c];
      @(negedge clk);
      lg_led[c]  = led;
      lg_busy[c] = busy;
      lg_drop[c] = dropped;
      lg_pend[c] = int'(dut.pend_q);
    end
    trig = 1'b0;
  endtask

  task automatic verify(input int s);
    foreach (spans[i]) begin
      if (spans[i].scen == s) begin
        for (int c = spans[i].lo; c <= spans[i].hi; c++) begin
          check($sformatf("s%0d c%0d led", s, c), int'(lg_led[c]), int'(spans[i].led));
          check($sformatf("s%0d c%0d busy", s, c), int'(lg_busy[c]), int'(spans[i].busy));
          check($sformatf("s%0d c%0d dropped", s, c), int'(lg_drop[c]), int'(spans[i].drop));
          check($sformatf("s%0d c%0d pend", s, c), lg_pend[c], spans[i].pend);
        end
      end
    end
  endtask

  initial begin
    logic [199:0] pat;

    // Scenario 0: single trig at 10.
    spans.push_back(mk(0,  0, 10, 0, 0, 0, 0));
    spans.push_back(mk(0, 11, 22, 1, 1, 0, 0));
    spans.push_back(mk(0, 23, 30, 0, 1, 0, 0));
    spans.push_back(mk(0, 31, 59, 0, 0, 0, 0));
    // Scenario 1: trigs at 10 and 14.
    spans.push_back(mk(1,  0, 10, 0, 0, 0, 0));
    spans.push_back(mk(1, 11, 14, 1, 1, 0, 0));
    spans.push_back(mk(1, 15, 22, 1, 1, 0, 1));
    spans.push_back(mk(1, 23, 30, 0, 1, 0, 1));
    spans.push_back(mk(1, 31, 42, 1, 1, 0, 0));
    spans.push_back(mk(1, 43, 50, 0, 1, 0, 0));
    spans.push_back(mk(1, 51, 59, 0, 0, 0, 0));
    // Scenario 2: trig at 10, then five in ON at 12..16.
    spans.push_back(mk(2,  0, 10, 0, 0, 0, 0));
    spans.push_back(mk(2, 11, 12, 1, 1, 0, 0));
    spans.push_back(mk(2, 13, 13, 1, 1, 0, 1));
    spans.push_back(mk(2, 14, 14, 1, 1, 0, 2));
    spans.push_back(mk(2, 15, 16, 1, 1, 1, 3));
    spans.push_back(mk(2, 17, 22, 1, 1, 0, 3));
    spans.push_back(mk(2, 23, 30, 0, 1, 0, 3));
    spans.push_back(mk(2, 31, 42, 1, 1, 0, 2));
    spans.push_back(mk(2, 43, 50, 0, 1, 0, 2));
    spans.push_back(mk(2, 51, 62, 1, 1, 0, 1));
    spans.push_back(mk(2, 63, 70, 0, 1, 0, 1));
    spans.push_back(mk(2, 71, 82, 1, 1, 0, 0));
    spans.push_back(mk(2, 83, 90, 0, 1, 0, 0));
    spans.push_back(mk(2, 91, 99, 0, 0, 0, 0));
    // Scenario 3: trig held for cycles 10..34.
    spans.push_back(mk(3,   0,  10, 0, 0, 0, 0));
    spans.push_back(mk(3,  11,  11, 1, 1, 0, 0));
    spans.push_back(mk(3,  12,  12, 1, 1, 0, 1));
    spans.push_back(mk(3,  13,  13, 1, 1, 0, 2));
    spans.push_back(mk(3,  14,  22, 1, 1, 1, 3));
    spans.push_back(mk(3,  23,  29, 0, 1, 1, 3));
    spans.push_back(mk(3,  30,  30, 0, 1, 0, 3));
    spans.push_back(mk(3,  31,  34, 1, 1, 1, 3));
    spans.push_back(mk(3,  35,  42, 1, 1, 0, 3));
    spans.push_back(mk(3,  43,  50, 0, 1, 0, 3));
    spans.push_back(mk(3,  51,  62, 1, 1, 0, 2));
    spans.push_back(mk(3,  63,  70, 0, 1, 0, 2));
    spans.push_back(mk(3,  71,  82, 1, 1, 0, 1));
    spans.push_back(mk(3,  83,  90, 0, 1, 0, 1));
    spans.push_back(mk(3,  91, 102, 1, 1, 0, 0));
    spans.push_back(mk(3, 103, 110, 0, 1, 0, 0));
    spans.push_back(mk(3, 111, 119, 0, 0, 0, 0));

    // Reset state.
    #2 rst = 1'b1;
    #1;
    check("reset led", int'(led), 0);
    check("reset busy", int'(busy), 0);
    check("reset dropped", int'(dropped), 0);
    check("reset state", int'(dut.state_q), int'(IDLE));

    // trig held during reset and released with it is ignored.
    trig = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    trig = 1'b0;
    @(posedge clk);
    #1;
    check("trig in reset led", int'(led), 0);
    check("trig in reset busy", int'(busy), 0);
    check("trig in reset state", int'(dut.state_q), int'(IDLE));

    pat = '0; pat[10] = 1'b1;
    run(pat, 60);
    verify(0);

    pat = '0; pat[10] = 1'b1; pat[14] = 1'b1;
    run(pat, 60);
    verify(1);

    pat = '0; pat[10] = 1'b1;
    for (int c = 12; c <= 16; c++) pat[c] = 1'b1;
    run(pat, 100);
    verify(2);

    pat = '0;
    for (int c = 10; c < 35; c++) pat[c] = 1'b1;
    run(pat, 120);
    verify(3);

    // Asynchronous reset mid-ON with two events queued.
    trig = 1'b0;
    rst  = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1 trig = (c == 10) || (c == 12) || (c == 13);
    end
    @(negedge clk);
    check("pre-reset pend", int'(dut.pend_q), 2);
    check("pre-reset led", int'(led), 1);
    @(posedge clk);
    #1 trig = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async rst led", int'(led), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst dropped", int'(dropped), 0);
    check("async rst pend", int'(dut.pend_q), 0);
    check("async rst state", int'(dut.state_q), int'(IDLE));
    trig = 1'b1;
    @(posedge clk);
    #1;
    check("rst held trig led", int'(led), 0);
    rst = 1'b0;
    @(posedge clk);
    #1 trig = 1'b0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      check($sformatf("post-rst led k%0d", k), int'(led), (k < 12) ? 1 : 0);
      @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
